// File: rtl/instruction_fetch_unit_if.sv
// instruction_fetch_unit_if: memory read port, redirect request and fetched-word stream of the fetch unit.
interface instruction_fetch_unit_if;
    logic [31:0] read_address;
    logic [31:0] instruction_in;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instruction;
    logic [31:0] out_pc;
    logic        fault;
    modport master (
        output read_address, out_valid, out_instruction, out_pc, fault,
        input  instruction_in, redirect_valid, redirect_target, out_ready
    );
    modport slave (
        input  read_address, out_valid, out_instruction, out_pc, fault,
        output instruction_in, redirect_valid, redirect_target, out_ready
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: sequential PC fetch with one-deep output register, wrap, and redirect flush.
// Define IMEM_MISALIGN_TRAP_EN to trap misaligned redirect targets into a sticky FAULT state.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_LIMIT = 32'd64
) (
    input logic clk,
    input logic reset,
    instruction_fetch_unit_if.master bus
);
    typedef enum logic [1:0] {BOOT, FETCH, FAULT} state_t;
    state_t state;
    logic [31:0] pc, pc_inc, next_pc, target, redirect_pc, out_instruction, out_pc;
    logic out_valid, fault, free, misaligned;
    assign pc_inc = pc + 32'd4;
    assign next_pc = pc_inc >= PC_LIMIT ? RESET_PC : pc_inc;
    assign target = {bus.redirect_target[31:2], 2'b00};
    assign redirect_pc = target >= PC_LIMIT ? RESET_PC : target;
`ifdef IMEM_MISALIGN_TRAP_EN
    assign misaligned = |bus.redirect_target[1:0];
`else
    assign misaligned = 1'b0;
`endif
    assign free = !out_valid || bus.out_ready;
    assign bus.read_address = pc;
    assign bus.out_valid = out_valid;
    assign bus.out_instruction = out_instruction;
    assign bus.out_pc = out_pc;
    assign bus.fault = fault;
    // A redirect overrides both capture and stall; any handshake on that edge has already consumed the word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= BOOT;
            pc <= RESET_PC;
            out_valid <= 1'b0;
            out_instruction <= 32'h0;
            out_pc <= 32'h0;
            fault <= 1'b0;
        end else begin
            case (state)
                BOOT: state <= FETCH;
                FETCH: begin
                    if (bus.redirect_valid) begin
                        out_valid <= 1'b0;
                        if (misaligned) begin
                            state <= FAULT;
                            fault <= 1'b1;
                        end else begin
                            pc <= redirect_pc;
                        end
                    end else if (free) begin
                        out_instruction <= bus.instruction_in;
                        out_pc <= pc;
                        out_valid <= 1'b1;
                        pc <= next_pc;
                    end
                end
                default: state <= FAULT;
            endcase
        end
    end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed tests of streaming, stall, wrap, redirect, misalign and async reset.
module tb_instruction_fetch_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int failures = 0;
    instruction_fetch_unit_if bus();
    instruction_fetch_unit dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    // Instruction memory: each word encodes its own address.
    assign bus.instruction_in = 32'hCAFE_0000 | {16'h0, bus.read_address[15:0]};

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        bus.out_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_target = 32'h0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        reset = 1'b1;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.out_pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", bus.out_pc); end
        checks++; if (bus.out_instruction !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h exp=0", bus.out_instruction); end
        checks++; if (bus.fault !== 1'b0) begin failures++; $display("FAIL reset_fault got=%b exp=0", bus.fault); end
        checks++; if (bus.read_address !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", bus.read_address); end
        reset = 1'b0;
    endtask

    task automatic test_stream;
        do_reset();
        bus.out_ready = 1'b1;
        step();
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL boot_valid got=%b exp=0", bus.out_valid); end
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'(4 * i) || bus.out_instruction !== (32'hCAFE_0000 | 32'(4 * i))) begin
                failures++;
                $display("FAIL stream_%0d got v=%b pc=%h ins=%h exp v=1 pc=%h", i, bus.out_valid, bus.out_pc, bus.out_instruction, 4 * i);
            end
        end
    endtask

    task automatic test_stall;
        do_reset();
        bus.out_ready = 1'b1;
        repeat (4) step();
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'd8 || bus.out_instruction !== 32'hCAFE_0008 || bus.read_address !== 32'd12) begin
                failures++;
                $display("FAIL stall_%0d got v=%b pc=%h ins=%h addr=%h exp v=1 pc=8 addr=c", k, bus.out_valid, bus.out_pc, bus.out_instruction, bus.read_address);
            end
        end
        bus.out_ready = 1'b1;
        step();
        checks++; if (bus.out_pc !== 32'd12 || bus.out_valid !== 1'b1) begin failures++; $display("FAIL stall_release got pc=%h v=%b exp pc=c v=1", bus.out_pc, bus.out_valid); end
    endtask

    task automatic test_wrap;
        do_reset();
        bus.out_ready = 1'b1;
        repeat (17) step();
        checks++; if (bus.out_pc !== 32'd60) begin failures++; $display("FAIL wrap_last got=%h exp=3c", bus.out_pc); end
        step();
        checks++; if (bus.out_pc !== 32'd0 || bus.out_valid !== 1'b1) begin failures++; $display("FAIL wrap_first got pc=%h v=%b exp pc=0 v=1", bus.out_pc, bus.out_valid); end
        step();
        checks++; if (bus.out_pc !== 32'd4) begin failures++; $display("FAIL wrap_next got=%h exp=4", bus.out_pc); end
    endtask

    task automatic test_redirect;
        do_reset();
        bus.out_ready = 1'b1;
        repeat (4) step();
        bus.out_ready = 1'b0;
        step();
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 32'h10;
        step();
        bus.redirect_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b0 || bus.read_address !== 32'h10) begin failures++; $display("FAIL redir_flush got v=%b addr=%h exp v=0 addr=10", bus.out_valid, bus.read_address); end
        step();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h10 || bus.out_instruction !== 32'hCAFE_0010) begin failures++; $display("FAIL redir_word got v=%b pc=%h ins=%h exp v=1 pc=10", bus.out_valid, bus.out_pc, bus.out_instruction); end
        step();
        checks++; if (bus.out_pc !== 32'h10 || bus.read_address !== 32'h14) begin failures++; $display("FAIL redir_hold got pc=%h addr=%h exp pc=10 addr=14", bus.out_pc, bus.read_address); end
    endtask

    task automatic test_handshake_redirect;
        do_reset();
        bus.out_ready = 1'b1;
        repeat (3) step();
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 32'h24;
        step();
        bus.redirect_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b0 || bus.read_address !== 32'h24) begin failures++; $display("FAIL hs_redir_flush got v=%b addr=%h exp v=0 addr=24", bus.out_valid, bus.read_address); end
        step();
        checks++; if (bus.out_pc !== 32'h24 || bus.out_valid !== 1'b1) begin failures++; $display("FAIL hs_redir_word got pc=%h v=%b exp pc=24 v=1", bus.out_pc, bus.out_valid); end
    endtask

    task automatic test_redirect_limit;
        do_reset();
        bus.out_ready = 1'b1;
        repeat (4) step();
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 32'h100;
        step();
        bus.redirect_valid = 1'b0;
        checks++; if (bus.read_address !== 32'h0 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL limit_addr got addr=%h v=%b exp addr=0 v=0", bus.read_address, bus.out_valid); end
        step();
        checks++; if (bus.out_pc !== 32'h0) begin failures++; $display("FAIL limit_word got=%h exp=0", bus.out_pc); end
    endtask

    task automatic test_boot_redirect;
        do_reset();
        bus.out_ready = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 32'h20;
        step();
        bus.redirect_valid = 1'b0;
        checks++; if (bus.read_address !== 32'h0) begin failures++; $display("FAIL boot_redir_addr got=%h exp=0", bus.read_address); end
        step();
        checks++; if (bus.out_pc !== 32'h0 || bus.out_valid !== 1'b1) begin failures++; $display("FAIL boot_redir_word got pc=%h v=%b exp pc=0 v=1", bus.out_pc, bus.out_valid); end
    endtask

    task automatic test_misalign;
        do_reset();
        bus.out_ready = 1'b1;
        repeat (3) step();
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 32'h0E;
        step();
        bus.redirect_valid = 1'b0;
`ifdef IMEM_MISALIGN_TRAP_EN
        bus.redirect_target = 32'h10;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (bus.fault !== 1'b1 || bus.out_valid !== 1'b0 || bus.read_address !== 32'h8) begin
                failures++;
                $display("FAIL trap_%0d got f=%b v=%b addr=%h exp f=1 v=0 addr=8", k, bus.fault, bus.out_valid, bus.read_address);
            end
            bus.redirect_valid = 1'b1;
            step();
        end
        do_reset();
        checks++; if (bus.fault !== 1'b0) begin failures++; $display("FAIL trap_clear got=%b exp=0", bus.fault); end
`else
        checks++; if (bus.fault !== 1'b0 || bus.out_valid !== 1'b0 || bus.read_address !== 32'h0C) begin failures++; $display("FAIL misalign_mask got f=%b v=%b addr=%h exp f=0 v=0 addr=c", bus.fault, bus.out_valid, bus.read_address); end
        step();
        checks++; if (bus.out_pc !== 32'h0C || bus.out_valid !== 1'b1) begin failures++; $display("FAIL misalign_word got pc=%h v=%b exp pc=c v=1", bus.out_pc, bus.out_valid); end
`endif
    endtask

    task automatic test_async_reset;
        do_reset();
        bus.out_ready = 1'b1;
        repeat (3) step();
        #2;
        reset = 1'b1;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.out_pc !== 32'h0 || bus.out_instruction !== 32'h0 || bus.read_address !== 32'h0) begin failures++; $display("FAIL async_reset got v=%b pc=%h ins=%h addr=%h exp all 0", bus.out_valid, bus.out_pc, bus.out_instruction, bus.read_address); end
        step();
        reset = 1'b0;
        step();
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL async_boot got=%b exp=0", bus.out_valid); end
        step();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0) begin failures++; $display("FAIL async_restart got v=%b pc=%h exp v=1 pc=0", bus.out_valid, bus.out_pc); end
    endtask

    initial begin
        bus.out_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_target = 32'h0;
        test_reset();
        test_stream();
        test_stall();
        test_wrap();
        test_redirect();
        test_handshake_redirect();
        test_redirect_limit();
        test_boot_redirect();
        test_misalign();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
